// File: rtl/store_buffer_if.sv
// Store-buffer bus: store/load requests from the datapath plus the
// single-port data-memory connection.
interface store_buffer_if;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        flush;
    logic        empty;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    modport master (
        output st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, flush, dm_rdata,
        input  st_ready, ld_data, empty, dm_we, dm_addr, dm_wdata
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, flush, dm_rdata,
        output st_ready, ld_data, empty, dm_we, dm_addr, dm_wdata
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO with byte-lane load forwarding and one-cycle RMW drain.
// Define STBUF_COALESCE_EN to merge stores into the youngest entry on a word match.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    store_buffer_if.slave  bus
);
    typedef struct packed {
        logic [29:0] word;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_nonempty;
    logic             w_drain;
    logic             w_hit;
    logic             w_acc;
    logic             w_push;
    logic [31:0]      w_fwd;
    logic [31:0]      w_wdata;
    logic [PTR_W-1:0] w_idx;
    logic             w_unused;

    assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign w_nonempty = (r_count != '0);
    assign w_drain    = !bus.ld_valid && w_nonempty;

`ifdef STBUF_COALESCE_EN
    logic [PTR_W-1:0] w_tail_m1;
    logic [31:0]      w_merged;
    logic             w_merge;

    assign w_tail_m1 = r_tail - 1'b1;
    // The youngest entry is off-limits when it is the one leaving this cycle.
    assign w_hit = w_nonempty && (r_mem[w_tail_m1].word == bus.st_addr[31:2])
                   && !((r_count == (PTR_W+1)'(1)) && w_drain);
    assign w_merge = w_acc && w_hit;

    always_comb begin
        w_merged = r_mem[w_tail_m1].data;
        for (int k = 0; k < 4; k++)
            if (bus.st_be[k]) w_merged[8*k +: 8] = bus.st_data[8*k +: 8];
    end
`else
    assign w_hit = 1'b0;
`endif

    assign bus.st_ready = !w_full || w_hit;
    assign bus.empty    = !w_nonempty;
    assign w_acc        = bus.st_valid && bus.st_ready && (bus.st_be != 4'b0000);
    assign w_push       = w_acc && !w_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)  r_tail <= r_tail + 1'b1;
            if (w_drain) r_head <= r_head + 1'b1;
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payloads are don't-care out of reset; validity comes from count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{word: bus.st_addr[31:2], data: bus.st_data, be: bus.st_be};
        end
`ifdef STBUF_COALESCE_EN
        else if (w_merge) begin
            r_mem[w_tail_m1].data <= w_merged;
            r_mem[w_tail_m1].be   <= r_mem[w_tail_m1].be | bus.st_be;
        end
`endif
    end

    // Oldest-to-youngest overlay so the most recent enabled byte wins.
    always_comb begin
        w_fwd = bus.dm_rdata;
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if (((PTR_W+1)'(i) < r_count) && (r_mem[w_idx].word == bus.ld_addr[31:2])) begin
                for (int k = 0; k < 4; k++)
                    if (r_mem[w_idx].be[k]) w_fwd[8*k +: 8] = r_mem[w_idx].data[8*k +: 8];
            end
        end
    end
    assign bus.ld_data = w_fwd;

    always_comb begin
        w_wdata = bus.dm_rdata;
        for (int k = 0; k < 4; k++)
            if (r_mem[r_head].be[k]) w_wdata[8*k +: 8] = r_mem[r_head].data[8*k +: 8];
    end
    assign bus.dm_wdata = w_wdata;

    always_comb begin
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h0;
        if (bus.ld_valid) begin
            bus.dm_addr = {bus.ld_addr[31:2], 2'b00};
        end else if (w_nonempty) begin
            bus.dm_we   = 1'b1;
            bus.dm_addr = {r_mem[r_head].word, 2'b00};
        end
    end

    // flush needs no state: draining already happens on every load-free cycle.
    assign w_unused = ^{bus.flush, bus.st_addr[1:0], bus.ld_addr[1:0]};
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer against a word-addressed memory model.
module tb_store_buffer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] mem [256];

    store_buffer_if sb ();

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign sb.dm_rdata = mem[sb.dm_addr[9:2]];
    always @(posedge clk) if (sb.dm_we) mem[sb.dm_addr[9:2]] <= sb.dm_wdata;

    function automatic logic [31:0] pat(input int i);
        return {8'hA5, 8'(i), 8'h5A, 8'(i)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        sb.st_valid = v;
        sb.st_addr  = a;
        sb.st_data  = d;
        sb.st_be    = be;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int j = 0; j < 256; j++) mem[j] = pat(j);
        mem[4] = 32'h11223344;
        rst = 1'b1;
        store(1'b0, 32'h0, 32'h0, 4'h0);
        sb.ld_valid = 1'b0;
        sb.ld_addr  = 32'h0;
        sb.flush    = 1'b0;

        // reset state
        #1;
        check("rst_empty", 32'(sb.empty), 32'd1);
        check("rst_ready", 32'(sb.st_ready), 32'd1);
        check("rst_we", 32'(sb.dm_we), 32'd0);
        check("rst_addr", sb.dm_addr, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // single-byte store merged with memory contents
        store(1'b1, 32'h10, 32'h0000AA00, 4'b0010);
        #1;
        check("bm_ready", 32'(sb.st_ready), 32'd1);
        check("bm_we_pre", 32'(sb.dm_we), 32'd0);
        tick();
        store(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("bm_we", 32'(sb.dm_we), 32'd1);
        check("bm_addr", sb.dm_addr, 32'h10);
        check("bm_wdata", sb.dm_wdata, 32'h1122AA44);
        tick();
        check("bm_empty", 32'(sb.empty), 32'd1);
        check("bm_mem", mem[4], 32'h1122AA44);

        // forwarding while a load holds the port
        sb.ld_valid = 1'b1;
        sb.ld_addr  = 32'h20;
        store(1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
        #1;
        check("fw_same_cycle", sb.ld_data, 32'hA5085A08);
        check("fw_we0", 32'(sb.dm_we), 32'd0);
        tick();
        store(1'b1, 32'h22, 32'h00000055, 4'b0001);
        #1;
        check("fw_one", sb.ld_data, 32'hDEADBEEF);
        tick();
        store(1'b0, 32'h0, 32'h0, 4'h0);
        sb.ld_addr = 32'h23;
        #1;
        check("fw_two", sb.ld_data, 32'hDEADBE55);
        check("fw_we1", 32'(sb.dm_we), 32'd0);
        check("fw_addr", sb.dm_addr, 32'h20);
        sb.ld_valid = 1'b0;
        sb.flush    = 1'b1;
        tick();
        tick();
        sb.flush = 1'b0;
        check("fw_empty", 32'(sb.empty), 32'd1);
        check("fw_mem", mem[8], 32'hDEADBE55);

        // zero byte-enable store is dropped
        sb.ld_valid = 1'b1;
        sb.ld_addr  = 32'h3FC;
        store(1'b1, 32'h30, 32'hFFFFFFFF, 4'h0);
        tick();
        store(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("be0_empty", 32'(sb.empty), 32'd1);

        // fill to DEPTH, then drain in FIFO order
        for (int i = 0; i < 4; i++) begin
            store(1'b1, 32'(4*i), 32'h0B0B0000 + 32'(i), 4'hF);
            #1;
            check("full_ready", 32'(sb.st_ready), 32'd1);
            tick();
        end
        store(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
        #1;
        check("full_block", 32'(sb.st_ready), 32'd0);
        check("full_fwd", sb.ld_data, pat(255));
        tick();
        store(1'b0, 32'h0, 32'h0, 4'h0);
        sb.ld_valid = 1'b0;
        #1;
        check("full_no_raise", 32'(sb.st_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_we", 32'(sb.dm_we), 32'd1);
            check("drain_addr", sb.dm_addr, 32'(4*i));
            check("drain_data", sb.dm_wdata, 32'h0B0B0000 + 32'(i));
            tick();
        end
        check("drain_empty", 32'(sb.empty), 32'd1);
        check("drain_skip", mem[12], pat(12));

        // push and drain every cycle across pointer wrap
        for (int i = 0; i < 10; i++) begin
            store(1'b1, 32'h80 + 32'(4*i), 32'hC0DE0000 + 32'(i), 4'hF);
            #1;
            check("wrap_ready", 32'(sb.st_ready), 32'd1);
            if (i > 0) check("wrap_addr", sb.dm_addr, 32'h80 + 32'(4*(i-1)));
            tick();
            check("wrap_busy", 32'(sb.empty), 32'd0);
        end
        store(1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("wrap_empty", 32'(sb.empty), 32'd1);
        for (int i = 0; i < 10; i++) check("wrap_mem", mem[32+i], 32'hC0DE0000 + 32'(i));

        // reset with three buffered stores: nothing reaches memory
        sb.ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            store(1'b1, 32'hC0 + 32'(4*i), 32'hBAD00000 + 32'(i), 4'hF);
            tick();
        end
        store(1'b0, 32'h0, 32'h0, 4'h0);
        sb.ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mrst_empty", 32'(sb.empty), 32'd1);
        check("mrst_ready", 32'(sb.st_ready), 32'd1);
        check("mrst_we", 32'(sb.dm_we), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) check("mrst_mem", mem[48+i], pat(48+i));

`ifdef STBUF_COALESCE_EN
        // second store to the youngest word merges even when full
        sb.ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            store(1'b1, 32'hD0 + 32'(4*i), 32'h77770000 + 32'(i), 4'hF);
            tick();
        end
        store(1'b1, 32'h40, 32'h00000011, 4'b0001);
        tick();
        store(1'b1, 32'h40, 32'h22000000, 4'b1000);
        #1;
        check("co_ready", 32'(sb.st_ready), 32'd1);
        check("co_fwd_pre", sb.ld_data, pat(255));
        tick();
        store(1'b0, 32'h0, 32'h0, 4'h0);
        sb.ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("co_empty", 32'(sb.empty), 32'd1);
        check("co_mem", mem[16], 32'h22105A11);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the datapath's memory stage and the word-addressed data memory (combinational read, synchronous write, single shared address port).
- Accepts byte-enabled stores into a small FIFO so they cost no extra cycle, then drains them to data memory when the port is idle.
- Forwards buffered bytes to loads so that a load always returns program-order-correct data.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_valid  in  1  store request this cycle.
- st_addr  in  32  store byte address; the word index is st_addr[31:2].
- st_data  in  32  store data, already lane-aligned.
- st_be  in  4  byte enables; bit k enables bits [8k+7:8k].
- st_ready  out  1  store can be accepted this cycle.
- ld_valid  in  1  load request this cycle.
- ld_addr  in  32  load byte address.
- ld_data  out  32  forwarded load word (combinational).
- flush  in  1  request a full drain (for example before halt or a memory dump).
- empty  out  1  buffer holds no entries.
- dm_we  out  1  to data memory write enable.
- dm_addr  out  32  to data memory address.
- dm_wdata  out  32  to data memory write data.
- dm_rdata  in  32  from data memory combinational read data.

Behaviour:
- Storage: DEPTH entries, each holding {word index[29:0], data[31:0], be[3:0]}. State is head pointer, tail pointer and count[PTR_W:0].
- Reset (asynchronous, active-high): head=0, tail=0, count=0. Resulting outputs: st_ready=1, empty=1, dm_we=0. Entry contents are don't-care.
- Reset mid-operation discards all buffered stores, with none written to memory.
- st_ready = (count != DEPTH), evaluated on pre-edge state. A drain in the same cycle does not raise st_ready.
- Push: if st_valid && st_ready, on the edge write the entry at tail, then tail++ (wraps mod DEPTH) and count++.
- st_be == 0 is accepted and discarded: no entry is allocated and st_ready is unaffected.
- Port arbitration (combinational):
  - If ld_valid is high: dm_addr = {ld_addr[31:2], 2'b00} and dm_we = 0. Loads have priority.
  - Else if count != 0: drain. dm_addr = {head.word, 2'b00} and dm_we = 1.
  - dm_wdata is built per byte lane: head.be[k] ? head.data lane : dm_rdata lane. This is a read-modify-write in one cycle.
  - On the edge after a drain: head++ and count--.
  - Otherwise: dm_we = 0 and dm_addr = 0.
- Simultaneous push and drain: count is unchanged and both pointers advance.
- Forwarding: ld_data starts from dm_rdata. Every valid entry whose word index equals ld_addr[31:2] is overlaid byte-wise, walking oldest to youngest, so the youngest enabled byte wins.
- A store presented in the same cycle as a load is not forwarded. Program order means the load precedes that store.
- flush: no extra state. The buffer drains one entry per load-free cycle, and empty is asserted once count == 0.
- st_ready stays as defined during a flush. The upstream side must stall stores itself if it needs a clean drain.
- Latency:
  - Stores take zero cycles from the producer's view.
  - A store reaches memory at least 1 cycle after it is accepted.
  - Worst-case drain is DEPTH load-free cycles.
- Address bits [1:0] are ignored by the buffer. dm_addr is always word-aligned.

Optional Feature:
- Macro: STBUF_COALESCE_EN.
- Defined: a push whose word index equals the youngest entry (tail-1) merges into that entry instead of allocating a new one.
  - Merge rule: data lanes with st_be set overwrite; be |= st_be.
  - The merge is allowed even when full, so st_ready = !full || coalesce-hit.
  - No merge when that entry is being drained in the same cycle (count == 1 and draining); a normal push occurs instead.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset mid-drain: fill 3 entries, assert rst for one cycle with no clock edge → empty=1, st_ready=1, dm_we=0 immediately. Memory keeps its old values at those addresses.
- Byte merge: mem[0x10] = 0x11223344; store be=4'b0010, data=0x0000AA00, addr 0x10; idle 1 cycle → dm_we=1, dm_wdata=0x1122AA44, then empty=1.
- Forwarding: with ld_valid held high, store 0xDEADBEEF be=F to 0x20, then be=4'b0001 data=0x00000055 to 0x20; load 0x20 → ld_data=0xDEADBE55, dm_we=0 throughout.
- Full: DEPTH stores back-to-back while ld_valid is held → 5th store sees st_ready=0. Drop ld_valid → drains in FIFO order to addresses 0x0, 0x4, 0x8, 0xC, one per cycle.
- Wrap and concurrency: alternate push and drain for 10 cycles → count stays at 1, pointers wrap, and all 10 words are correct in memory.
- With STBUF_COALESCE_EN defined: two stores to 0x40 (be=1 then be=8) while full-1 → one entry is used and memory receives the combined word.
